// File: rtl/reg_readback_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// reg_readback_fsm : walks the register file onto the ALU bus and holds
// each captured value for the hex display.                     Rev 1.0
// ==========================================================================
module reg_readback_fsm #(
   parameter int unsigned HOLD_CYCLES = 50_000_000,
   parameter int unsigned FIRST_REG   = 0,
   parameter int unsigned LAST_REG    = 15,
   parameter logic [7:0]  OP_PASS     = 8'h0D
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic        pause_i,
   input  logic [15:0] alu_bus_i,
   output logic [4:0]  mux_a_o,
   output logic [4:0]  mux_b_o,
   output logic [7:0]  alu_op_o,
   output logic        imm_control_o,
   output logic [15:0] regs_en_o,
   output logic        buff_en_o,
   output logic [3:0]  reg_index_o,
   output logic [15:0] display_value_o,
   output logic        value_valid_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam int unsigned      CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [3:0]       FIRST_IDX = 4'(FIRST_REG);
   localparam logic [3:0]       LAST_IDX  = 4'(LAST_REG);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DRIVE   = 3'd1,
      S_CAPTURE = 3'd2,
      S_HOLD    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] hold_cnt_q;
   logic [3:0]       reg_index_q;
   logic [4:0]       mux_a_q;
   logic [15:0]      display_q;
   logic             valid_q;
   logic             buff_en_q;
   logic             busy_q;
   logic             done_q;

   // Datapath controls that never change: pass-through op, no writes.
   assign mux_b_o         = 5'd0;
   assign alu_op_o        = OP_PASS;
   assign imm_control_o   = 1'b0;
   assign regs_en_o       = 16'h0000;

   assign mux_a_o         = mux_a_q;
   assign buff_en_o       = buff_en_q;
   assign reg_index_o     = reg_index_q;
   assign display_value_o = display_q;
   assign value_valid_o   = valid_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         hold_cnt_q  <= '0;
         reg_index_q <= FIRST_IDX;
         mux_a_q     <= {1'b0, FIRST_IDX};
         display_q   <= 16'h0000;
         valid_q     <= 1'b0;
         buff_en_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state_q     <= S_DRIVE;
                  reg_index_q <= FIRST_IDX;
                  mux_a_q     <= {1'b0, FIRST_IDX};
                  buff_en_q   <= 1'b1;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
               end
            end
            S_DRIVE: begin
               state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               state_q    <= S_HOLD;
               display_q  <= alu_bus_i;
               hold_cnt_q <= HOLD_LOAD;
               valid_q    <= 1'b1;
               buff_en_q  <= 1'b0;
            end
            S_HOLD: begin
               if (!pause_i) begin
                  if (hold_cnt_q != '0) begin
                     hold_cnt_q <= hold_cnt_q - CNT_ONE;
                  end else if (reg_index_q == LAST_IDX) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     // Bus is re-driven one full cycle ahead of the next capture.
                     state_q     <= S_DRIVE;
                     reg_index_q <= reg_index_q + 4'd1;
                     mux_a_q     <= {1'b0, reg_index_q + 4'd1};
                     buff_en_q   <= 1'b1;
                  end
               end
            end
            default: begin
               state_q   <= S_IDLE;
               buff_en_q <= 1'b0;
               busy_q    <= 1'b0;
               done_q    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_readback_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// tb_reg_readback_fsm : directed scans against a timeline model of the
// read-back sequencer, with a combinational register-file/ALU stand-in.
module tb_reg_readback_fsm;

   logic        clk = 1'b0;
   logic        reset_i = 1'b0;
   logic        start_i = 1'b0;
   logic        pause_i = 1'b0;
   logic        start_b = 1'b0;

   logic [15:0] alu_bus_a, alu_bus_b;
   logic [4:0]  mux_a_a, mux_b_a, mux_a_b, mux_b_b;
   logic [7:0]  alu_op_a, alu_op_b;
   logic        imm_a, imm_b;
   logic [15:0] regs_en_a, regs_en_b;
   logic        buff_a, buff_b;
   logic [3:0]  idx_a, idx_b;
   logic [15:0] disp_a, disp_b;
   logic        valid_a, valid_b;
   logic        busy_a, busy_b;
   logic        done_a, done_b;

   int checks   = 0;
   int failures = 0;
   logic [15:0] model_disp = 16'h0000;
   int valid_t[16];

   always #5 clk = ~clk;

   // Register file rN = 0x1111*N seen through a pass-through ALU; anything
   // other than a correctly configured, enabled read yields junk.
   assign alu_bus_a = (buff_a && alu_op_a == 8'h0D && !imm_a && mux_b_a == 5'd0 && !mux_a_a[4])
                      ? 16'(16'h1111 * {12'd0, mux_a_a[3:0]}) : 16'hDEAD;
   assign alu_bus_b = (buff_b && alu_op_b == 8'h0D && !imm_b && mux_a_b == 5'd3)
                      ? 16'hBEEF : 16'hDEAD;

   reg_readback_fsm #(.HOLD_CYCLES(4), .FIRST_REG(0), .LAST_REG(15), .OP_PASS(8'h0D)) u_dut_a (
      .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .pause_i(pause_i),
      .alu_bus_i(alu_bus_a), .mux_a_o(mux_a_a), .mux_b_o(mux_b_a), .alu_op_o(alu_op_a),
      .imm_control_o(imm_a), .regs_en_o(regs_en_a), .buff_en_o(buff_a),
      .reg_index_o(idx_a), .display_value_o(disp_a), .value_valid_o(valid_a),
      .busy_o(busy_a), .done_o(done_a)
   );

   reg_readback_fsm #(.HOLD_CYCLES(4), .FIRST_REG(3), .LAST_REG(3), .OP_PASS(8'h0D)) u_dut_b (
      .clk_i(clk), .reset_i(reset_i), .start_i(start_b), .pause_i(1'b0),
      .alu_bus_i(alu_bus_b), .mux_a_o(mux_a_b), .mux_b_o(mux_b_b), .alu_op_o(alu_op_b),
      .imm_control_o(imm_b), .regs_en_o(regs_en_b), .buff_en_o(buff_b),
      .reg_index_o(idx_b), .display_value_o(disp_b), .value_valid_o(valid_b),
      .busy_o(busy_b), .done_o(done_b)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full scan of DUT A; the expected timeline is built from DRIVE start times.
   task automatic run_scan(input string tag, input int pause_reg, input int pause_len, input bit toggle);
      int d[17];
      int t_end, nvalid, done_t, k, ph;
      int bad_v, bad_b, bad_d, bad_busy, bad_done, bad_idx, bad_mux, bad_const;
      bit in_scan, exp_valid, exp_buff;
      nvalid = 0; done_t = -1;
      bad_v = 0; bad_b = 0; bad_d = 0; bad_busy = 0; bad_done = 0;
      bad_idx = 0; bad_mux = 0; bad_const = 0;
      for (int j = 0; j <= 16; j++)
         d[j] = 6 * j + ((pause_reg >= 0 && j > pause_reg) ? pause_len : 0);
      t_end = d[16];
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int t = 0; t <= t_end + 3; t++) begin
         k = 0;
         for (int j = 0; j < 16; j++) if (t >= d[j]) k = j;
         ph        = t - d[k];
         in_scan   = (t < t_end);
         exp_valid = in_scan && ph == 2;
         exp_buff  = in_scan && ph < 2;
         if (exp_valid) model_disp = 16'(16'h1111 * k);
         if (t == 0) begin
            chk_eq({tag, "_busy_t0"}, 32'(busy_a), 32'd1);
            chk_eq({tag, "_done_t0"}, 32'(done_a), 32'd0);
         end
         if (valid_a !== exp_valid)       bad_v++;
         if (buff_a !== exp_buff)         bad_b++;
         if (disp_a !== model_disp)       bad_d++;
         if (busy_a !== in_scan)          bad_busy++;
         if (done_a !== !in_scan)         bad_done++;
         if (idx_a !== 4'(k))             bad_idx++;
         if (mux_a_a !== {1'b0, 4'(k)})   bad_mux++;
         if (regs_en_a !== 16'h0 || mux_b_a !== 5'd0 || alu_op_a !== 8'h0D || imm_a !== 1'b0)
            bad_const++;
         if (valid_a === 1'b1) begin
            if (nvalid < 16) valid_t[nvalid] = t;
            nvalid++;
         end
         if (done_a === 1'b1 && done_t < 0) done_t = t;
         pause_i = (pause_reg >= 0 && t >= d[pause_reg] + 3 && t < d[pause_reg] + 3 + pause_len);
         start_i = toggle && (t % 2 == 1) && (t < t_end - 1);
         step();
      end
      pause_i = 1'b0;
      start_i = 1'b0;
      chk_eq({tag, "_valid_pattern"}, 32'(bad_v), 32'd0);
      chk_eq({tag, "_buff_en_pattern"}, 32'(bad_b), 32'd0);
      chk_eq({tag, "_display_track"}, 32'(bad_d), 32'd0);
      chk_eq({tag, "_busy_pattern"}, 32'(bad_busy), 32'd0);
      chk_eq({tag, "_done_pattern"}, 32'(bad_done), 32'd0);
      chk_eq({tag, "_reg_index"}, 32'(bad_idx), 32'd0);
      chk_eq({tag, "_mux_a"}, 32'(bad_mux), 32'd0);
      chk_eq({tag, "_constants"}, 32'(bad_const), 32'd0);
      chk_eq({tag, "_valid_count"}, 32'(nvalid), 32'd16);
      chk_eq({tag, "_done_time"}, 32'(done_t), 32'(t_end));
      chk_eq({tag, "_last_value"}, 32'(disp_a), 32'h0000FFFF);
   endtask

   initial begin
      int nv, dt;
      reset_i = 1'b1;
      step();
      step();
      reset_i = 1'b0;
      chk_eq("rst_busy", 32'(busy_a), 32'd0);
      chk_eq("rst_done", 32'(done_a), 32'd0);
      chk_eq("rst_buff_en", 32'(buff_a), 32'd0);
      chk_eq("rst_valid", 32'(valid_a), 32'd0);
      chk_eq("rst_display", 32'(disp_a), 32'd0);
      chk_eq("rst_mux_a", 32'(mux_a_a), 32'd0);
      chk_eq("rst_mux_b", 32'(mux_b_a), 32'd0);
      chk_eq("rst_alu_op", 32'(alu_op_a), 32'h0D);
      chk_eq("rst_imm", 32'(imm_a), 32'd0);
      chk_eq("rst_regs_en", 32'(regs_en_a), 32'd0);
      chk_eq("rst_b_index", 32'(idx_b), 32'd3);
      chk_eq("rst_b_mux_a", 32'(mux_a_b), 32'd3);

      // Idle with no start: nothing moves.
      step();
      step();
      chk_eq("idle_busy", 32'(busy_a), 32'd0);

      run_scan("base", -1, 0, 1'b0);
      chk_eq("base_valid_spacing", 32'(valid_t[15] - valid_t[0]), 32'd90);
      run_scan("from_done", -1, 0, 1'b0);
      run_scan("pause", 5, 10, 1'b0);
      chk_eq("pause_r5_valid_t", 32'(valid_t[5]), 32'd32);
      chk_eq("pause_r6_valid_t", 32'(valid_t[6]), 32'd48);
      run_scan("toggle", -1, 0, 1'b1);

      // Reset landing on the CAPTURE cycle of r7 (DRIVE at t=42).
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int t = 0; t < 43; t++) step();
      chk_eq("pre_rst_index", 32'(idx_a), 32'd7);
      chk_eq("pre_rst_buff_en", 32'(buff_a), 32'd1);
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      model_disp = 16'h0000;
      chk_eq("mid_rst_display", 32'(disp_a), 32'd0);
      chk_eq("mid_rst_valid", 32'(valid_a), 32'd0);
      chk_eq("mid_rst_buff_en", 32'(buff_a), 32'd0);
      chk_eq("mid_rst_busy", 32'(busy_a), 32'd0);
      chk_eq("mid_rst_done", 32'(done_a), 32'd0);
      chk_eq("mid_rst_index", 32'(idx_a), 32'd0);
      chk_eq("mid_rst_mux_a", 32'(mux_a_a), 32'd0);
      step();
      chk_eq("post_rst_valid", 32'(valid_a), 32'd0);
      chk_eq("post_rst_idle", 32'(busy_a), 32'd0);
      run_scan("after_rst", -1, 0, 1'b0);

      // Single-register scan on DUT B.
      nv = 0;
      dt = -1;
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      for (int t = 0; t < 12; t++) begin
         if (valid_b === 1'b1) nv++;
         if (done_b === 1'b1 && dt < 0) dt = t;
         step();
      end
      chk_eq("single_valid_count", 32'(nv), 32'd1);
      chk_eq("single_display", 32'(disp_b), 32'hBEEF);
      chk_eq("single_done_time", 32'(dt), 32'd6);
      chk_eq("single_index", 32'(idx_b), 32'd3);
      chk_eq("single_regs_en", 32'(regs_en_b), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reg_readback_fsm.md
# reg_readback_fsm

Sequential read-side controller for the ALU/register-file datapath. It walks the register file from a first to a last index and selects each register onto the ALU output bus through the A mux and a pass-through ALU op. It captures the bus value into a display register and holds it for a programmable time so the 7-segment hex display can show it. It is the reader counterpart to the Fibonacci write sequencer: it never asserts a register write enable.

## Interface

Parameters:
- HOLD_CYCLES, 50_000_000: cycles each captured value is held (1 s at 50 MHz); must be ≥1.
- FIRST_REG, 0: first register index read (0–15).
- LAST_REG, 15: last register index read (FIRST_REG ≤ LAST_REG ≤ 15).
- OP_PASS, 8'h0D: ALU op encoding that passes operand A to the output unchanged.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; one clock, the only reset.
- start  in  1  level, sampled each cycle; begins a scan when in IDLE or DONE.
- pause  in  1  freezes the hold counter while high.
- alu_bus  in  16  ALU_Out_Bus from the ALU/register block.
- mux_a  out  5  A-mux select, {1'b0, reg_index}.
- mux_b  out  5  B-mux select, constant 5'd0.
- alu_op  out  8  constant OP_PASS.
- imm_control  out  1  constant 0 (register operand, not immediate).
- regs_en  out  16  constant 16'h0000 (no writes, ever).
- buff_en  out  1  tri-state buffer enable onto the bus.
- reg_index  out  4  register currently selected/displayed.
- display_value  out  16  last captured bus value, feeds the hex decoders.
- value_valid  out  1  one-cycle pulse when display_value updates.
- busy  out  1  high from DRIVE through the end of the last HOLD.
- done  out  1  high while in DONE.

## Operation

- States: IDLE, DRIVE, CAPTURE, HOLD, DONE.
- IDLE: buff_en=0. start=1 → DRIVE with reg_index=FIRST_REG.
- DRIVE (1 cycle): buff_en=1, mux_a selects reg_index. This is the bus settle cycle → CAPTURE.
- CAPTURE (1 cycle): buff_en=1.
  - At the exiting edge: display_value ← alu_bus, hold counter ← HOLD_CYCLES-1, value_valid ← 1.
  - → HOLD.
- HOLD: buff_en=0; value_valid is high only in the first HOLD cycle.
  - Counter decrements each cycle with pause=0 and holds when pause=1.
  - Counter==0 with pause=0: reg_index==LAST_REG → DONE, else reg_index+1 → DRIVE.
- DONE: done=1, busy=0, display_value retains the last value. start=1 → DRIVE with reg_index=FIRST_REG (restart).
- start while busy is ignored.
- pause outside HOLD has no effect.
- reg_index never wraps past LAST_REG; the 4-bit increment is only taken when reg_index<LAST_REG.
- mux_b, alu_op, imm_control and regs_en are constants in every state, including reset.

## Timing

- Reset values: state IDLE, reg_index=FIRST_REG, mux_a={1'b0,FIRST_REG}, display_value=0, value_valid=0, buff_en=0, busy=0, done=0.
- reset during any state forces these values at the next edge. It has priority over start and pause, and no capture occurs that cycle.
- start sampled at edge N (state IDLE):
  - DRIVE in cycle N+1.
  - CAPTURE in cycle N+2.
  - display_value/value_valid updated in cycle N+3.
- Per register: 2 + HOLD_CYCLES cycles, plus paused cycles.
- Full scan, no pause: (LAST_REG-FIRST_REG+1)·(2+HOLD_CYCLES) cycles from the first DRIVE to done=1.
- alu_bus must be valid in CAPTURE, one full cycle after mux_a/buff_en change. The ALU path is combinational within one cycle.
- All outputs are registered or constant; no combinational input-to-output path.

## Test plan

- Use HOLD_CYCLES=4, registers preloaded rN=16'h1111·N (mod 2^16), pulse start one cycle.
  - Required: 16 value_valid pulses spaced 6 cycles apart, display_value 0000,1111,…,FFFF (r15), done=1 96 cycles after the first DRIVE.
  - Required: buff_en is never high in HOLD, and regs_en=0 throughout.
- Hold pause=1 for 10 cycles mid-HOLD of r5.
  - Required: r5 HOLD lasts 14 cycles, r6 value_valid delayed by exactly 10 cycles, display_value stable at 16'h5555.
- Toggle start repeatedly while busy.
  - Required: no change to sequence or timing versus the first test.
- Assert reset for one cycle while in CAPTURE of r7.
  - Required: next cycle all outputs at reset values, display_value=0, no value_valid pulse.
  - Required: a subsequent start restarts at r0.
- Set FIRST_REG=LAST_REG=3, r3=16'hBEEF.
  - Required: exactly one value_valid, display_value=BEEF, done=1 after 6 cycles.
- From DONE, assert start again.
  - Required: busy=1 and done=0 the next cycle; the scan repeats identically from FIRST_REG.
